write_back_mux_skid: RTL and testbench
======================================

Name: write_back_mux_skid

Overview:
- Parametrised N-to-1 write-back result selector with a registered output stage and a valid/ready handshake.
- Selects one of NUM_INPUTS result buses (ALU, load, PC+4, CSR, ...) by a binary SELECT code.
- Tags the selected result with its destination register address and presents it to the register-file write port.
- A 2-entry skid buffer allows full throughput under back-pressure, and out-of-range selects are flagged.

Parameters:
- BUS_WIDTH, 32, width of each data input and of OUT_DATA.
- NUM_INPUTS, 4, number of selectable inputs (>=2).
- SEL_WIDTH, 2, width of SELECT. Must satisfy 2**SEL_WIDTH >= NUM_INPUTS.
- ZERO_X0, 1, when 1, any transfer with IN_RD_ADDR==0 stores OUT_DATA=0.

Ports:
- CLK  input  1  clock, rising edge.
- RST_N  input  1  asynchronous active-low reset.
- IN_DATA  input  NUM_INPUTS*BUS_WIDTH  packed inputs; input k occupies bits [k*BUS_WIDTH +: BUS_WIDTH].
- SELECT  input  SEL_WIDTH  binary index of the input to forward.
- IN_RD_ADDR  input  5  destination register address.
- IN_VALID  input  1  upstream beat valid.
- IN_READY  output  1  block can accept a beat.
- OUT_DATA  output  BUS_WIDTH  selected, registered result.
- OUT_RD_ADDR  output  5  registered destination address.
- OUT_VALID  output  1  output beat valid.
- OUT_READY  input  1  downstream accepts the beat.
- SEL_ERROR  output  1  sticky flag: an accepted beat had SELECT >= NUM_INPUTS.

Behaviour:
- Reset (RST_N low, asynchronous, takes effect immediately):
  - OUT_DATA=0, OUT_RD_ADDR=0, OUT_VALID=0, SEL_ERROR=0.
  - Main and skid entries are invalidated; IN_READY=1 once the skid entry is empty, including during reset.
- Reset mid-operation: all in-flight beats (main and skid) are discarded, with no partial output.
- Input accept: IN_VALID && IN_READY on a rising edge. Output accept: OUT_VALID && OUT_READY.
- Selection and packing at input accept:
  - Beat = {rd, data}, where data = input[SELECT] if SELECT < NUM_INPUTS, else 0.
  - If ZERO_X0==1 and rd==0, data is forced to 0.
- Storage:
  - Main register drives the OUT_* ports directly.
  - Skid register holds one extra beat.
  - IN_READY = !skid_valid, taken straight from a flop with no combinational path from OUT_READY.
- Per-edge rules:
  - Main empty or being consumed, and skid empty: an accepted beat loads main.
  - Main full and not consumed: an accepted beat loads skid.
  - Main consumed and skid full: skid moves to main. No input accept can occur, since IN_READY=0.
  - Simultaneous input accept and output accept with skid empty: the new beat replaces main, OUT_VALID stays 1, and there is no bubble.
- Latency: 1 cycle from input accept to OUT_VALID. Throughput: 1 beat/cycle while OUT_READY=1.
- Ordering: strictly FIFO; the skid beat always exits before any newer beat.
- OUT_DATA and OUT_RD_ADDR hold steady while OUT_VALID=1 and OUT_READY=0.
- When the block is empty, OUT_DATA and OUT_RD_ADDR keep the last value and OUT_VALID=0.
- SEL_ERROR:
  - Set on the edge of any input accept with SELECT >= NUM_INPUTS.
  - Stays set until reset; that beat is still forwarded with data 0.
  - SELECT is ignored when there is no input accept.
- Maximum occupancy is 2. With OUT_READY=0, two beats are accepted, then IN_READY falls to 0 on the second accept's edge.

Test Plan:
- Reset then idle:
  - RST_N=0 for 3 cycles → OUT_VALID=0, OUT_DATA=0, SEL_ERROR=0, IN_READY=1.
  - Asserting RST_N mid-stream clears OUT_VALID in the same cycle, without waiting for a clock edge.
- Full-rate streaming, NUM_INPUTS=4, OUT_READY=1:
  - Inputs 0x11111111/0x22222222/0x33333333/0x44444444; SELECT=0,1,2,3 on consecutive cycles with rd=5.
  - Required: OUT_DATA 0x11111111, 0x22222222, 0x33333333, 0x44444444 on cycles +1..+4, with OUT_VALID high on every cycle.
- Back-pressure:
  - OUT_READY=0; send beats A (rd=1) and B (rd=2).
  - Required: IN_READY=0 after B; OUT holds A. Release OUT_READY → A then B with no loss or duplication; IN_READY returns to 1.
- x0 suppression: ZERO_X0=1, rd=0, SELECT=1 with input1=0xDEADBEEF → OUT_DATA=0, OUT_RD_ADDR=0.
- Bad select: NUM_INPUTS=3, SELECT=3 accepted → OUT_DATA=0 and SEL_ERROR=1, which stays 1 through later valid beats until RST_N.
- Randomized scoreboard: random IN_VALID, OUT_READY and SELECT over 10k cycles → output stream equals the reference queue in order, and IN_READY never depends combinationally on OUT_READY.

Source files
------------

// File: rtl/write_back_mux_skid.sv
// write_back_mux_skid: N-to-1 write-back result selector with registered output,
// valid/ready handshake, 2-entry skid buffer and sticky out-of-range select flag.
module write_back_mux_skid #(
    parameter int BUS_WIDTH  = 32,
    parameter int NUM_INPUTS = 4,
    parameter int SEL_WIDTH  = 2,
    parameter int ZERO_X0    = 1
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic [NUM_INPUTS*BUS_WIDTH-1:0] in_data_i,
    input  logic [SEL_WIDTH-1:0]            select_i,
    input  logic [4:0]                      in_rd_addr_i,
    input  logic                            in_valid_i,
    output logic                            in_ready_o,
    output logic [BUS_WIDTH-1:0]            out_data_o,
    output logic [4:0]                      out_rd_addr_o,
    output logic                            out_valid_o,
    input  logic                            out_ready_i,
    output logic                            sel_error_o
);
    logic                 main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
    logic [BUS_WIDTH-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
    logic [4:0]           main_rd_q, main_rd_d, skid_rd_q, skid_rd_d;
    logic                 sel_err_q, sel_err_d;
    logic [BUS_WIDTH-1:0] beat_data;
    logic                 sel_hit, in_acc;

    assign in_acc = in_valid_i && !skid_valid_q;

    always_comb begin
        beat_data = '0;
        sel_hit   = 1'b0;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            if (select_i == SEL_WIDTH'(k)) begin
                beat_data = in_data_i[k*BUS_WIDTH +: BUS_WIDTH];
                sel_hit   = 1'b1;
            end
        end
        if (ZERO_X0 != 0 && in_rd_addr_i == 5'd0) beat_data = '0;
    end

    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        main_rd_d    = main_rd_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_rd_d    = skid_rd_q;
        sel_err_d    = sel_err_q || (in_acc && !sel_hit);
        if (!main_valid_q || out_ready_i) begin
            // a pending skid beat always drains first; input is stalled while it exists
            if (skid_valid_q) begin
                main_valid_d = 1'b1;
                main_data_d  = skid_data_q;
                main_rd_d    = skid_rd_q;
                skid_valid_d = 1'b0;
            end else begin
                main_valid_d = in_acc;
                main_data_d  = in_acc ? beat_data : main_data_q;
                main_rd_d    = in_acc ? in_rd_addr_i : main_rd_q;
            end
        end else if (in_acc) begin
            skid_valid_d = 1'b1;
            skid_data_d  = beat_data;
            skid_rd_d    = in_rd_addr_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            main_valid_q <= 1'b0;
            main_data_q  <= '0;
            main_rd_q    <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_rd_q    <= '0;
            sel_err_q    <= 1'b0;
        end else begin
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            main_rd_q    <= main_rd_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_rd_q    <= skid_rd_d;
            sel_err_q    <= sel_err_d;
        end
    end

    assign in_ready_o    = !skid_valid_q;
    assign out_valid_o   = main_valid_q;
    assign out_data_o    = main_data_q;
    assign out_rd_addr_o = main_rd_q;
    assign sel_error_o   = sel_err_q;
endmodule

// File: tb/tb_write_back_mux_skid.sv
// tb_write_back_mux_skid: directed and random checks of a 4-input and a 3-input
// instance against a queue-based reference of the write-back stage.
module tb_write_back_mux_skid;
    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] d4;
        logic [31:0] d3;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] in_w [4];
    logic [1:0]  sel = '0;
    logic [4:0]  rd = '0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [127:0] in_data4;
    logic [95:0]  in_data3;
    logic        ir4, ov4, err4, ir3, ov3, err3;
    logic [31:0] od4, od3;
    logic [4:0]  ord4, ord3;

    int vectors = 0;
    int miscompares = 0;

    beat_t q[$];
    beat_t last;
    logic  m_err3;

    assign in_data4 = {in_w[3], in_w[2], in_w[1], in_w[0]};
    assign in_data3 = {in_w[2], in_w[1], in_w[0]};

    always #5 clk = ~clk;

    write_back_mux_skid #(.BUS_WIDTH(32), .NUM_INPUTS(4), .SEL_WIDTH(2), .ZERO_X0(1)) u4 (
        .clk_i(clk), .rst_ni(rst_n), .in_data_i(in_data4), .select_i(sel),
        .in_rd_addr_i(rd), .in_valid_i(in_valid), .in_ready_o(ir4),
        .out_data_o(od4), .out_rd_addr_o(ord4), .out_valid_o(ov4),
        .out_ready_i(out_ready), .sel_error_o(err4));

    write_back_mux_skid #(.BUS_WIDTH(32), .NUM_INPUTS(3), .SEL_WIDTH(2), .ZERO_X0(1)) u3 (
        .clk_i(clk), .rst_ni(rst_n), .in_data_i(in_data3), .select_i(sel),
        .in_rd_addr_i(rd), .in_valid_i(in_valid), .in_ready_o(ir3),
        .out_data_o(od3), .out_rd_addr_o(ord3), .out_valid_o(ov3),
        .out_ready_i(out_ready), .sel_error_o(err3));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic beat_t mk();
        beat_t b;
        b.rd = rd;
        b.d4 = in_w[sel];
        b.d3 = (sel < 2'd3) ? in_w[sel] : 32'd0;
        if (rd == 5'd0) begin
            b.d4 = 32'd0;
            b.d3 = 32'd0;
        end
        return b;
    endfunction

    // Reference: an ordered queue of at most two beats
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            last   = '0;
            m_err3 = 1'b0;
        end else begin
            automatic bit ia = in_valid && q.size() < 2;
            automatic bit oa = q.size() > 0 && out_ready;
            if (oa) void'(q.pop_front());
            if (ia) q.push_back(mk());
            if (ia && sel == 2'd3) m_err3 = 1'b1;
            if (q.size() > 0) last = q[0];
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            automatic beat_t e = (q.size() > 0) ? q[0] : last;
            automatic logic  full = (q.size() >= 2);
            automatic logic  nonempty = (q.size() > 0);
            chk("in_ready4", ir4, !full);
            chk("in_ready3", ir3, !full);
            chk("out_valid4", ov4, nonempty);
            chk("out_valid3", ov3, nonempty);
            chk("out_data4", od4, e.d4);
            chk("out_data3", od3, e.d3);
            chk("out_rd4", ord4, e.rd);
            chk("out_rd3", ord3, e.rd);
            chk("sel_error4", err4, 1'b0);
            chk("sel_error3", err3, m_err3);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] s, input logic [4:0] r);
        in_valid = v;
        sel      = s;
        rd       = r;
    endtask

    initial begin
        logic [31:0] stream_exp [4];
        stream_exp[0] = 32'h11111111;
        stream_exp[1] = 32'h22222222;
        stream_exp[2] = 32'h33333333;
        stream_exp[3] = 32'h44444444;
        in_w = stream_exp;

        repeat (3) tick();
        chk("rst_out_valid", ov4, 1'b0);
        chk("rst_out_data", od4, 32'd0);
        chk("rst_sel_error", err3, 1'b0);
        chk("rst_in_ready", ir4, 1'b1);
        rst_n = 1'b1;
        tick();

        out_ready = 1'b1;
        for (int s = 0; s < 4; s++) begin
            drive(1'b1, 2'(s), 5'd5);
            tick();
            chk("stream_data", od4, stream_exp[s]);
            chk("stream_valid", ov4, 1'b1);
            chk("stream_rd", ord4, 5'd5);
        end
        drive(1'b0, 2'd0, 5'd0);
        tick();
        chk("stream_drained", ov4, 1'b0);
        chk("stream_hold_data", od4, 32'h44444444);

        out_ready = 1'b0;
        drive(1'b1, 2'd0, 5'd1);
        tick();
        chk("bp_ready_after_a", ir4, 1'b1);
        drive(1'b1, 2'd1, 5'd2);
        tick();
        chk("bp_ready_after_b", ir4, 1'b0);
        chk("bp_hold_rd", ord4, 5'd1);
        chk("bp_hold_data", od4, 32'h11111111);
        drive(1'b0, 2'd0, 5'd0);
        tick();
        chk("bp_still_a", od4, 32'h11111111);
        out_ready = 1'b1;
        tick();
        chk("bp_b_rd", ord4, 5'd2);
        chk("bp_b_data", od4, 32'h22222222);
        chk("bp_ready_back", ir4, 1'b1);
        tick();
        chk("bp_empty", ov4, 1'b0);

        in_w[1] = 32'hDEADBEEF;
        drive(1'b1, 2'd1, 5'd0);
        tick();
        chk("x0_data", od4, 32'd0);
        chk("x0_rd", ord4, 5'd0);
        chk("x0_valid", ov4, 1'b1);

        drive(1'b1, 2'd3, 5'd7);
        tick();
        chk("badsel_data3", od3, 32'd0);
        chk("badsel_err3", err3, 1'b1);
        chk("badsel_data4", od4, 32'h44444444);
        chk("badsel_err4", err4, 1'b0);
        drive(1'b1, 2'd0, 5'd3);
        tick();
        chk("badsel_sticky", err3, 1'b1);
        chk("badsel_next_data3", od3, 32'h11111111);

        out_ready = 1'b0;
        drive(1'b1, 2'd2, 5'd9);
        tick();
        drive(1'b0, 2'd0, 5'd0);
        #2;
        chk("arst_pre_valid", ov4, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("arst_valid4", ov4, 1'b0);
        chk("arst_valid3", ov3, 1'b0);
        chk("arst_err3", err3, 1'b0);
        chk("arst_in_ready", ir4, 1'b1);
        tick();
        rst_n = 1'b1;
        tick();

        for (int c = 0; c < 10000; c++) begin
            for (int k = 0; k < 4; k++) in_w[k] = $urandom;
            drive(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)));
            out_ready = ($urandom_range(0, 2) != 0);
            if (c % 8 == 0) begin
                out_ready = ~out_ready;
                #1;
                chk("in_ready_comb", ir4, q.size() < 2);
                out_ready = ~out_ready;
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
